// File: rtl/gate_equiv_checker_pkg.sv
// ---------------------------------------------------------------------------
// gate_equiv_checker_pkg
// Shared definitions for the gate equivalence checker: the sweep FSM state
// encoding used by the top level.
// ---------------------------------------------------------------------------
package gate_equiv_checker_pkg;

  // Sweep FSM states. DRIVE gives the compared implementations a full cycle
  // to settle on the new vector; SAMPLE performs the compare.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRIVE  = 2'd1,
    S_SAMPLE = 2'd2,
    S_FINISH = 2'd3
  } state_t;

endpackage

// File: rtl/gate_equiv_checker_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Saturating up-counter with synchronous clear. Holds at all-ones instead of
// wrapping, so a large mismatch count never reads back as a small one.
//
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous, active-high; clears count
//   clr    - synchronous clear (takes priority over inc)
//   inc    - increment by one when not saturated
//   count  - current count value, W bits
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] ONE = W'(1);

  // Count register: clear wins over increment, increment stops at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/gate_equiv_checker.sv
// ---------------------------------------------------------------------------
// gate_equiv_checker
// Sweep-and-compare engine. On start it walks vec_out through every value
// 0 .. 2^N_IN-1, giving two combinational implementations of the same gate
// one cycle to settle on each vector and then comparing their outputs.
// Mismatches are counted (saturating) and the first failing vector is kept.
//
// Ports:
//   clk             - rising-edge clock
//   reset           - asynchronous, active-high; clears all state
//   start           - request a sweep; only honoured in IDLE
//   resp_a, resp_b  - outputs of the two implementations under comparison
//   vec_out         - input vector driven to both implementations
//   busy            - sweep in progress (DRIVE or SAMPLE)
//   done            - one-cycle pulse at end of sweep
//   pass            - last completed sweep had zero mismatches
//   err_count       - mismatches in the current/last sweep (saturating)
//   first_err_vec   - vector of the first mismatch in the last sweep
//   first_err_valid - first_err_vec holds a valid capture
// ---------------------------------------------------------------------------
module gate_equiv_checker
  import gate_equiv_checker_pkg::*;
#(
  parameter int N_IN  = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             resp_a,
  input  logic             resp_b,
  output logic [N_IN-1:0]  vec_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [N_IN-1:0]  first_err_vec,
  output logic             first_err_valid
);

  localparam logic [N_IN-1:0] VEC_ONE = N_IN'(1);

  state_t state;
  state_t state_nxt;

  logic mismatch;
  logic last_vec;
  logic sweep_start;
  logic err_inc;

  assign mismatch    = resp_a ^ resp_b;
  assign last_vec    = (vec_out == '1);
  assign sweep_start = (state == S_IDLE) && start;
  assign err_inc     = (state == S_SAMPLE) && mismatch;

  assign busy = (state == S_DRIVE) || (state == S_SAMPLE);
  assign done = (state == S_FINISH);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. start outside IDLE is deliberately ignored, so a held
  // start only relaunches once the FSM is back in IDLE after FINISH.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_DRIVE;
      S_DRIVE:  state_nxt = S_SAMPLE;
      S_SAMPLE: state_nxt = last_vec ? S_FINISH : S_DRIVE;
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Vector stepping, first-failure capture and pass verdict. Results hold in
  // IDLE until the next accepted start clears them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vec_out         <= '0;
      pass            <= 1'b0;
      first_err_vec   <= '0;
      first_err_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            vec_out         <= '0;
            pass            <= 1'b0;
            first_err_vec   <= '0;
            first_err_valid <= 1'b0;
          end
        end
        S_SAMPLE: begin
          if (mismatch && !first_err_valid) begin
            first_err_vec   <= vec_out;
            first_err_valid <= 1'b1;
          end
          // The verdict must include the compare happening on this same
          // edge, which the counter has not absorbed yet.
          if (last_vec) begin
            pass <= (err_count == '0) && !mismatch;
          end else begin
            vec_out <= vec_out + VEC_ONE;
          end
        end
        default: begin
        end
      endcase
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_err_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (sweep_start),
    .inc   (err_inc),
    .count (err_count)
  );

endmodule

// File: tb/tb_gate_equiv_checker.sv
// ---------------------------------------------------------------------------
// tb_gate_equiv_checker
// Bench for gate_equiv_checker. Two instances: a 2-input checker with an
// 8-bit counter and a 3-input checker with a 2-bit counter (saturation).
// The compared implementations are modelled here as simple gate functions
// selected by 'mode'. Expected sweep results are pushed to a scoreboard
// when a sweep is launched and popped when the done pulse is observed.
// ---------------------------------------------------------------------------
module tb_gate_equiv_checker;

  typedef struct {
    int errs;
    bit pass;
    int fvec;
    bit fvalid;
    int lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       start2;
  logic       start3;
  int         mode;

  logic       resp_a2, resp_b2, resp_a3, resp_b3;
  logic [1:0] vec2, fvec2;
  logic [7:0] err2;
  logic       busy2, done2, pass2, fval2;
  logic [2:0] vec3, fvec3;
  logic [1:0] err3;
  logic       busy3, done3, pass3, fval3;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  // Observations gathered by run_sweep.
  int vec_log[$];
  int busy_cnt;
  int done_cnt;
  int done_at;
  int obs_err;
  bit obs_pass;
  int obs_fvec;
  bit obs_fvalid;

  always #5 clk = ~clk;

  // Implementation A: NAND, or constant 0 in mode 3.
  function automatic bit gate_a(input int m, input int v);
    bit x, y;
    x = v[1];
    y = v[0];
    if (m == 3) return 1'b0;
    return ~(x & y);
  endfunction

  // Implementation B: NAND / AND / OR / constant 1 by mode.
  function automatic bit gate_b(input int m, input int v);
    bit x, y;
    x = v[1];
    y = v[0];
    case (m)
      0:       return ~(x & y);
      1:       return x & y;
      2:       return x | y;
      default: return 1'b1;
    endcase
  endfunction

  // Reference sweep result from the gate truth tables.
  function automatic exp_t model(input int m, input int n, input int cw);
    exp_t e;
    int cnt, first, sat;
    cnt   = 0;
    first = -1;
    for (int v = 0; v < (1 << n); v++) begin
      if (gate_a(m, v) != gate_b(m, v)) begin
        cnt++;
        if (first < 0) first = v;
      end
    end
    sat      = (1 << cw) - 1;
    e.errs   = (cnt > sat) ? sat : cnt;
    e.pass   = (cnt == 0);
    e.fvec   = (first < 0) ? 0 : first;
    e.fvalid = (first >= 0);
    e.lat    = 1 << (n + 1);
    return e;
  endfunction

  assign resp_a2 = gate_a(mode, int'(vec2));
  assign resp_b2 = gate_b(mode, int'(vec2));
  assign resp_a3 = gate_a(mode, int'(vec3));
  assign resp_b3 = gate_b(mode, int'(vec3));

  gate_equiv_checker #(.N_IN(2), .CNT_W(8)) u_dut2 (
    .clk(clk), .reset(reset), .start(start2),
    .resp_a(resp_a2), .resp_b(resp_b2),
    .vec_out(vec2), .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err2), .first_err_vec(fvec2), .first_err_valid(fval2)
  );

  gate_equiv_checker #(.N_IN(3), .CNT_W(2)) u_dut3 (
    .clk(clk), .reset(reset), .start(start3),
    .resp_a(resp_a3), .resp_b(resp_b3),
    .vec_out(vec3), .busy(busy3), .done(done3), .pass(pass3),
    .err_count(err3), .first_err_vec(fvec3), .first_err_valid(fval3)
  );

  // Launch one sweep and record what the DUT does, cycle by cycle. Cycle 0 is
  // the cycle after the edge that accepts start. Optionally re-pulses start.
  task automatic run_sweep(input bit use3, input int budget, input int extra_start_at);
    bit b, d;
    vec_log.delete();
    busy_cnt = 0;
    done_cnt = 0;
    done_at  = -1;
    @(negedge clk);
    if (use3) start3 = 1'b1; else start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    start3 = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (i > 0) @(negedge clk);
      b = use3 ? busy3 : busy2;
      d = use3 ? done3 : done2;
      if (b) begin
        vec_log.push_back(use3 ? int'(vec3) : int'(vec2));
        busy_cnt++;
      end
      if (d) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at    = i;
          obs_err    = use3 ? int'(err3) : int'(err2);
          obs_pass   = use3 ? pass3 : pass2;
          obs_fvec   = use3 ? int'(fvec3) : int'(fvec2);
          obs_fvalid = use3 ? fval3 : fval2;
        end
      end
      if (use3) start3 = (i == extra_start_at);
      else      start2 = (i == extra_start_at);
      if (done_at >= 0 && i >= done_at + 3) break;
    end
    start2 = 1'b0;
    start3 = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({vec2, busy2, done2, pass2, err2, fvec2, fval2} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_dut2: got %h expected 0", {vec2, busy2, done2, pass2, err2, fvec2, fval2});
    end
    checks++;
    if ({vec3, busy3, done3, pass3, err3, fvec3, fval3} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_dut3: got %h expected 0", {vec3, busy3, done3, pass3, err3, fvec3, fval3});
    end
    reset = 1'b0;
  endtask

  task automatic test_equal();
    exp_t e;
    mode = 0;
    sb.push_back(model(0, 2, 8));
    run_sweep(1'b0, 40, -1);
    e = sb.pop_front();
    checks++;
    if (done_at !== e.lat) begin
      errors++; $display("[TB] FAIL equal_latency: got %0d expected %0d", done_at, e.lat);
    end
    checks++;
    if (busy_cnt !== 8) begin
      errors++; $display("[TB] FAIL equal_busy_cycles: got %0d expected 8", busy_cnt);
    end
    for (int k = 0; k < vec_log.size(); k++) begin
      checks++;
      if (vec_log[k] !== k / 2) begin
        errors++; $display("[TB] FAIL equal_vec_step%0d: got %0d expected %0d", k, vec_log[k], k / 2);
      end
    end
    checks++;
    if (obs_err !== e.errs || obs_pass !== e.pass || obs_fvalid !== e.fvalid) begin
      errors++;
      $display("[TB] FAIL equal_result: got err=%0d pass=%0b fvalid=%0b expected err=%0d pass=%0b fvalid=%0b",
               obs_err, obs_pass, obs_fvalid, e.errs, e.pass, e.fvalid);
    end
  endtask

  task automatic test_nand_and();
    exp_t e;
    mode = 1;
    sb.push_back(model(1, 2, 8));
    run_sweep(1'b0, 40, -1);
    e = sb.pop_front();
    checks++;
    if (done_cnt !== 1 || done_at !== e.lat) begin
      errors++; $display("[TB] FAIL and_done: got count=%0d at=%0d expected 1 at %0d", done_cnt, done_at, e.lat);
    end
    checks++;
    if (obs_err !== e.errs) begin
      errors++; $display("[TB] FAIL and_err_count: got %0d expected %0d", obs_err, e.errs);
    end
    checks++;
    if (obs_pass !== e.pass) begin
      errors++; $display("[TB] FAIL and_pass: got %0b expected %0b", obs_pass, e.pass);
    end
    checks++;
    if (obs_fvec !== e.fvec || obs_fvalid !== e.fvalid) begin
      errors++; $display("[TB] FAIL and_first_err: got vec=%0d valid=%0b expected vec=%0d valid=%0b",
                         obs_fvec, obs_fvalid, e.fvec, e.fvalid);
    end
  endtask

  task automatic test_nand_or();
    exp_t e;
    mode = 2;
    sb.push_back(model(2, 2, 8));
    run_sweep(1'b0, 40, -1);
    e = sb.pop_front();
    checks++;
    if (obs_err !== e.errs) begin
      errors++; $display("[TB] FAIL or_err_count: got %0d expected %0d", obs_err, e.errs);
    end
    checks++;
    if (obs_fvec !== e.fvec || obs_fvalid !== e.fvalid || obs_pass !== e.pass) begin
      errors++; $display("[TB] FAIL or_result: got vec=%0d valid=%0b pass=%0b expected vec=%0d valid=%0b pass=%0b",
                         obs_fvec, obs_fvalid, obs_pass, e.fvec, e.fvalid, e.pass);
    end
    // Results must hold in IDLE after the sweep.
    repeat (4) @(negedge clk);
    checks++;
    if (int'(err2) !== e.errs || pass2 !== e.pass || busy2 !== 1'b0) begin
      errors++; $display("[TB] FAIL or_hold_idle: got err=%0d pass=%0b busy=%0b expected err=%0d pass=%0b busy=0",
                         err2, pass2, busy2, e.errs, e.pass);
    end
  endtask

  task automatic test_saturate();
    exp_t e;
    mode = 3;
    sb.push_back(model(3, 3, 2));
    run_sweep(1'b1, 60, -1);
    e = sb.pop_front();
    checks++;
    if (done_at !== e.lat) begin
      errors++; $display("[TB] FAIL sat_latency: got %0d expected %0d", done_at, e.lat);
    end
    checks++;
    if (obs_err !== e.errs) begin
      errors++; $display("[TB] FAIL sat_err_count: got %0d expected %0d", obs_err, e.errs);
    end
    checks++;
    if (obs_pass !== e.pass || obs_fvec !== e.fvec || obs_fvalid !== e.fvalid) begin
      errors++; $display("[TB] FAIL sat_result: got pass=%0b vec=%0d valid=%0b expected pass=%0b vec=%0d valid=%0b",
                         obs_pass, obs_fvec, obs_fvalid, e.pass, e.fvec, e.fvalid);
    end
  endtask

  task automatic test_ignore_start();
    exp_t e;
    mode = 2;
    sb.push_back(model(2, 2, 8));
    run_sweep(1'b0, 40, 3);
    e = sb.pop_front();
    checks++;
    if (done_cnt !== 1 || done_at !== e.lat) begin
      errors++; $display("[TB] FAIL ignore_done: got count=%0d at=%0d expected 1 at %0d", done_cnt, done_at, e.lat);
    end
    checks++;
    if (obs_err !== e.errs) begin
      errors++; $display("[TB] FAIL ignore_err_count: got %0d expected %0d", obs_err, e.errs);
    end
  endtask

  task automatic test_mid_reset();
    exp_t e;
    int dones;
    mode = 1;
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({vec2, busy2, done2, pass2, err2, fvec2, fval2} !== '0) begin
      errors++;
      $display("[TB] FAIL midreset_async: got %h expected 0", {vec2, busy2, done2, pass2, err2, fvec2, fval2});
    end
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done2) dones++;
    end
    checks++;
    if (dones !== 0) begin
      errors++; $display("[TB] FAIL midreset_no_done: got %0d pulses expected 0", dones);
    end
    mode = 0;
    sb.push_back(model(0, 2, 8));
    run_sweep(1'b0, 40, -1);
    e = sb.pop_front();
    checks++;
    if (done_at !== e.lat || obs_err !== e.errs || obs_pass !== e.pass || obs_fvalid !== e.fvalid) begin
      errors++; $display("[TB] FAIL midreset_clean_sweep: got at=%0d err=%0d pass=%0b fvalid=%0b expected at=%0d err=%0d pass=%0b fvalid=%0b",
                         done_at, obs_err, obs_pass, obs_fvalid, e.lat, e.errs, e.pass, e.fvalid);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int dones;
    int at[$];
    mode = 2;
    sb.push_back(model(2, 2, 8));
    sb.push_back(model(2, 2, 8));
    dones = 0;
    @(negedge clk);
    start2 = 1'b1;
    for (int i = 0; i < 40 && dones < 2; i++) begin
      @(negedge clk);
      if (i == 9) begin
        checks++;
        if (busy2 !== 1'b0 || done2 !== 1'b0) begin
          errors++; $display("[TB] FAIL b2b_idle_gap: got busy=%0b done=%0b expected 0 0", busy2, done2);
        end
      end
      if (done2) begin
        dones++;
        at.push_back(i);
        e = sb.pop_front();
        checks++;
        if (int'(err2) !== e.errs || pass2 !== e.pass) begin
          errors++; $display("[TB] FAIL b2b_result%0d: got err=%0d pass=%0b expected err=%0d pass=%0b",
                             dones, err2, pass2, e.errs, e.pass);
        end
      end
    end
    start2 = 1'b0;
    checks++;
    if (at.size() !== 2) begin
      errors++; $display("[TB] FAIL b2b_done_count: got %0d expected 2", at.size());
    end else begin
      checks++;
      if (at[0] !== 8 || at[1] !== 18) begin
        errors++; $display("[TB] FAIL b2b_done_cycles: got %0d,%0d expected 8,18", at[0], at[1]);
      end
    end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    reset  = 1'b1;
    start2 = 1'b0;
    start3 = 1'b0;
    mode   = 0;
    repeat (2) @(negedge clk);
    test_reset();
    test_equal();
    test_nand_and();
    test_nand_or();
    test_saturate();
    test_ignore_start();
    test_mid_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
